// File: rtl/race_engine.sv
// race_engine: N-kart race engine sharing one trig ROM, with race FSM, lap counting and winner
module race_engine #(
    parameter int NUM_KARTS    = 2,
    parameter int LAPS         = 3,
    parameter int MAX_SPEED    = 6,
    parameter int ACCEL        = 1,
    parameter int BOUND_MIN    = 64,
    parameter int BOUND_MAX    = 1984,
    parameter int FIN_X0       = 96,
    parameter int FIN_X1       = 160,
    parameter int FIN_Y0       = 64,
    parameter int FIN_Y1       = 128,
    parameter int CHK_Y        = 1024,
    parameter int COUNT_FRAMES = 180,
    parameter int TRIG_LAT     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_frame_tick,
    input  logic                     i_start,
    input  logic [NUM_KARTS-1:0]     i_steer_l,
    input  logic [NUM_KARTS-1:0]     i_steer_r,
    input  logic [NUM_KARTS-1:0]     i_throttle,
    output logic [8:0]               o_trig_addr,
    input  logic signed [10:0]       i_trig_cos,
    input  logic signed [10:0]       i_trig_sin,
    output logic [11*NUM_KARTS-1:0]  o_kart_x,
    output logic [11*NUM_KARTS-1:0]  o_kart_y,
    output logic [9*NUM_KARTS-1:0]   o_kart_dir,
    output logic [3*NUM_KARTS-1:0]   o_kart_laps,
    output logic [1:0]               o_race_state,
    output logic [2:0]               o_winner,
    output logic                     o_frame_done
);
    localparam int KW = NUM_KARTS > 1 ? $clog2(NUM_KARTS) : 1;
    localparam int CW = $clog2(COUNT_FRAMES + 1);
    localparam logic [CW-1:0] CNT_END = CW'(COUNT_FRAMES - 1);
    localparam logic [KW-1:0] K_END = KW'(NUM_KARTS - 1);
    localparam logic [3:0] WC_END = 4'(TRIG_LAT - 1);
    localparam logic signed [12:0] BMIN = 13'(BOUND_MIN);
    localparam logic signed [12:0] BMAX = 13'(BOUND_MAX);

    typedef enum logic [1:0] {R_WAIT, R_CD, R_RACE, R_DONE} race_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_UPD, S_FIN} sweep_t;

    race_t r_race, w_race_n;
    sweep_t r_sw, w_sw_n;
    logic [CW-1:0] r_cnt;
    logic [3:0] r_wc;
    logic [KW-1:0] r_k, r_winner;
    logic r_won;
    logic [8:0] r_trig_addr;
    logic [10:0] r_x [NUM_KARTS];
    logic [10:0] r_y [NUM_KARTS];
    logic [8:0] r_dir [NUM_KARTS];
    logic [3:0] r_spd [NUM_KARTS];
    logic [2:0] r_laps [NUM_KARTS];
    logic [NUM_KARTS-1:0] r_latch;
    logic [10:0] r_cx, r_cy;
    logic [8:0] r_cd;
    logic [3:0] r_cs;
    logic [2:0] r_claps;
    logic r_cl;
    logic w_cap, w_upd;
    logic [4:0] w_sum;
    logic [3:0] w_spd_n;
    logic [8:0] w_dir_n;
    logic signed [15:0] w_px, w_py;
    logic signed [12:0] w_nx, w_ny;
    logic [10:0] w_x_n, w_y_n;
    logic w_box, w_lap, w_latch_n, w_win;
    logic [2:0] w_laps_n;

    // race state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_race <= R_WAIT;
        else r_race <= w_race_n;
    end

    // race next state: advances on frame ticks, DONE entered at the end of the winning sweep
    always_comb begin
        w_race_n = r_race;
        case (r_race)
            R_WAIT:  w_race_n = (i_frame_tick && i_start) ? R_CD : R_WAIT;
            R_CD:    w_race_n = (i_frame_tick && r_cnt >= CNT_END) ? R_RACE : R_CD;
            R_RACE:  w_race_n = (r_sw == S_FIN && r_won) ? R_DONE : R_RACE;
            default: w_race_n = R_DONE;
        endcase
    end

    // race outputs
    always_comb begin
        o_race_state = r_race;
        o_winner = 3'(r_winner);
    end

    // countdown counter; the tick that leaves WAIT counts as the first countdown frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (r_race == R_WAIT && i_frame_tick && i_start) r_cnt <= CW'(1);
        else if (r_race == R_CD && i_frame_tick) r_cnt <= r_cnt + 1'b1;
    end

    // sweep state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sw <= S_IDLE;
        else r_sw <= w_sw_n;
    end

    // sweep next state: address, wait out ROM latency, update, repeat per kart
    always_comb begin
        w_sw_n = r_sw;
        case (r_sw)
            S_IDLE:  w_sw_n = (i_frame_tick && r_race == R_RACE) ? S_ADDR : S_IDLE;
            S_ADDR:  w_sw_n = (TRIG_LAT == 0) ? S_UPD : S_WAIT;
            S_WAIT:  w_sw_n = (r_wc == WC_END) ? S_UPD : S_WAIT;
            S_UPD:   w_sw_n = (r_k == K_END) ? S_FIN : S_ADDR;
            default: w_sw_n = S_IDLE;
        endcase
    end

    // sweep outputs and strobes
    always_comb begin
        o_frame_done = r_sw == S_FIN;
        w_cap = r_sw == S_ADDR;
        w_upd = r_sw == S_UPD;
        o_trig_addr = r_trig_addr;
    end

    // next kart state from the captured copy and the ROM result
    always_comb begin
        w_sum = {1'b0, r_cs} + 5'(ACCEL);
        w_spd_n = i_throttle[r_k] ? (w_sum > 5'(MAX_SPEED) ? 4'(MAX_SPEED) : w_sum[3:0])
                                  : (r_cs == 4'd0 ? 4'd0 : r_cs - 4'd1);
        w_dir_n = (i_steer_l[r_k] && !i_steer_r[r_k]) ? (r_cd == 9'd359 ? 9'd0 : r_cd + 9'd1) :
                  (i_steer_r[r_k] && !i_steer_l[r_k]) ? (r_cd == 9'd0 ? 9'd359 : r_cd - 9'd1) : r_cd;
        w_px = $signed({12'd0, w_spd_n}) * $signed({{5{i_trig_cos[10]}}, i_trig_cos});
        w_py = $signed({12'd0, w_spd_n}) * $signed({{5{i_trig_sin[10]}}, i_trig_sin});
        w_nx = $signed({2'b00, r_cx}) + 13'(w_px >>> 9);
        w_ny = $signed({2'b00, r_cy}) - 13'(w_py >>> 9);
        w_x_n = 11'(w_nx < BMIN ? BMIN : w_nx > BMAX ? BMAX : w_nx);
        w_y_n = 11'(w_ny < BMIN ? BMIN : w_ny > BMAX ? BMAX : w_ny);
        w_box = w_x_n >= 11'(FIN_X0) && w_x_n <= 11'(FIN_X1) &&
                w_y_n >= 11'(FIN_Y0) && w_y_n <= 11'(FIN_Y1);
        w_lap = r_cl && w_box && r_cd <= 9'd180;
        w_latch_n = !w_lap && (r_cl || w_y_n >= 11'(CHK_Y));
        w_laps_n = (w_lap && r_claps < 3'(LAPS)) ? r_claps + 3'd1 : r_claps;
        w_win = w_lap && r_claps == 3'(LAPS - 1) && !r_won;
    end

    // kart state, capture registers, ROM address and winner latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_KARTS; k++) begin
                r_x[k] <= 11'(128 + 128 * k);
                r_y[k] <= 11'd100;
                r_dir[k] <= '0;
                r_spd[k] <= '0;
                r_laps[k] <= '0;
            end
            r_latch <= '0;
            r_k <= '0;
            r_wc <= '0;
            r_cx <= '0;
            r_cy <= '0;
            r_cd <= '0;
            r_cs <= '0;
            r_cl <= 1'b0;
            r_claps <= '0;
            r_trig_addr <= '0;
            r_winner <= '0;
            r_won <= 1'b0;
        end else begin
            if (w_cap) begin
                r_cx <= r_x[r_k];
                r_cy <= r_y[r_k];
                r_cd <= r_dir[r_k];
                r_cs <= r_spd[r_k];
                r_cl <= r_latch[r_k];
                r_claps <= r_laps[r_k];
                r_trig_addr <= r_dir[r_k];
                r_wc <= '0;
            end
            if (r_sw == S_WAIT) r_wc <= r_wc + 4'd1;
            if (w_upd) begin
                r_x[r_k] <= w_x_n;
                r_y[r_k] <= w_y_n;
                r_dir[r_k] <= w_dir_n;
                r_spd[r_k] <= w_spd_n;
                r_laps[r_k] <= w_laps_n;
                r_latch[r_k] <= w_latch_n;
                r_k <= (r_k == K_END) ? '0 : r_k + 1'b1;
                if (w_win) begin
                    r_winner <= r_k;
                    r_won <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_KARTS; g++) begin : g_out
        assign o_kart_x[11*g+:11] = r_x[g];
        assign o_kart_y[11*g+:11] = r_y[g];
        assign o_kart_dir[9*g+:9] = r_dir[g];
        assign o_kart_laps[3*g+:3] = r_laps[g];
    end
endmodule
